// File: rtl/ping_pong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ping_pong_pkg
// Brief   : Shared types for the ping-pong bank write/read controller.
// Revision: 1.0 - initial release
// ============================================================================
package ping_pong_pkg;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_e;

  typedef enum logic [0:0] {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_sel_e;

  // A single slice pass still needs a 1-bit index port.
  function automatic int slice_width(input int modules);
    return (modules > 1) ? $clog2(modules) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ping_pong_w_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ping_pong_w_ctrl_if
// Brief   : Handshake and dual-bank BRAM port bundle of the ping-pong controller.
// Revision: 1.0 - initial release
// ============================================================================
interface ping_pong_w_ctrl_if
  import ping_pong_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int TOTAL_MODULES = 4
);
  localparam int c_slice_w = slice_width(TOTAL_MODULES);

  logic                  in_valid;
  logic                  in_ready;
  logic                  sa_ready;
  logic                  bank0_ena;
  logic                  bank0_wea;
  logic                  bank1_ena;
  logic                  bank1_wea;
  logic [ADDR_WIDTH-1:0] bank0_addra;
  logic [ADDR_WIDTH-1:0] bank1_addra;
  logic                  bank0_enb;
  logic                  bank1_enb;
  logic                  bank0_web;
  logic                  bank1_web;
  logic [ADDR_WIDTH-1:0] bank0_addrb;
  logic [ADDR_WIDTH-1:0] bank1_addrb;
  logic [c_slice_w-1:0]  slicing_idx;
  logic                  rd_valid;
  logic                  rd_bank;
  logic                  rd_last;
  logic [1:0]            bank_full;

  modport master (
    input  in_valid, sa_ready,
    output in_ready,
    output bank0_ena, bank0_wea, bank1_ena, bank1_wea, bank0_addra, bank1_addra,
    output bank0_enb, bank1_enb, bank0_web, bank1_web, bank0_addrb, bank1_addrb,
    output slicing_idx, rd_valid, rd_bank, rd_last, bank_full
  );

  modport slave (
    output in_valid, sa_ready,
    input  in_ready,
    input  bank0_ena, bank0_wea, bank1_ena, bank1_wea, bank0_addra, bank1_addra,
    input  bank0_enb, bank1_enb, bank0_web, bank1_web, bank0_addrb, bank1_addrb,
    input  slicing_idx, rd_valid, rd_bank, rd_last, bank_full
  );

endinterface
`default_nettype wire

// File: rtl/pp_addr_counter.sv
`default_nettype none
// ============================================================================
// Module  : pp_addr_counter
// Brief   : Enabled 0..MAX_COUNT wrap counter with a terminal-count flag.
// Revision: 1.0 - initial release
// ============================================================================
module pp_addr_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 11
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  output logic [WIDTH-1:0]      count,
  output logic                  terminal
);

  logic [WIDTH-1:0] r_count;

  assign terminal = (r_count == WIDTH'(MAX_COUNT));
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= terminal ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ping_pong_w_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ping_pong_w_ctrl
// Brief   : Fills two BRAM banks alternately and drains each full bank to the
//           systolic array in TOTAL_MODULES slice passes.
// Revision: 1.0 - initial release
// ============================================================================
module ping_pong_w_ctrl
  import ping_pong_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int TOTAL_DEPTH   = 12,
  parameter int TOTAL_MODULES = 4
) (
  input wire logic            clk,
  input wire logic            rst_n,
  ping_pong_w_ctrl_if.master  bus
);

  localparam int                   c_slice_w    = slice_width(TOTAL_MODULES);
  localparam logic [c_slice_w-1:0] c_last_slice = c_slice_w'(TOTAL_MODULES - 1);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  bank_sel_e             r_wr_sel;
  bank_sel_e             r_rd_sel;
  logic [1:0]            r_bank_full;
  logic [1:0]            w_full_nxt;
  logic [c_slice_w-1:0]  r_slice;
  logic                  r_rd_valid;
  logic                  r_rd_bank;
  logic                  r_rd_last;

  logic [ADDR_WIDTH-1:0] w_wr_cnt;
  logic [ADDR_WIDTH-1:0] w_rd_cnt;
  logic                  w_wr_term;
  logic                  w_rd_term;
  logic                  w_in_ready;
  logic                  w_beat;
  logic                  w_fill_done;
  logic                  w_reading;
  logic                  w_slice_end;
  logic                  w_drain_done;

  // Gating with rst_n keeps the combinational write enables low during reset.
  assign w_in_ready   = rst_n & ~r_bank_full[r_wr_sel];
  assign w_beat       = bus.in_valid & w_in_ready;
  assign w_fill_done  = w_beat & w_wr_term;
  assign w_reading    = (r_state == R_READ);
  assign w_slice_end  = w_reading & w_rd_term;
  assign w_drain_done = w_slice_end & (r_slice == c_last_slice);

  pp_addr_counter #(
    .WIDTH     (ADDR_WIDTH),
    .MAX_COUNT (TOTAL_DEPTH - 1)
  ) u_wr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_beat),
    .count    (w_wr_cnt),
    .terminal (w_wr_term)
  );

  pp_addr_counter #(
    .WIDTH     (ADDR_WIDTH),
    .MAX_COUNT (TOTAL_DEPTH - 1)
  ) u_rd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_reading),
    .count    (w_rd_cnt),
    .terminal (w_rd_term)
  );

  // A drain, once started, runs to completion regardless of sa_ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (r_bank_full[r_rd_sel] && bus.sa_ready) w_state_nxt = R_READ;
      R_READ:  if (w_drain_done) w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Fill and drain always target different banks, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_bank_full;
    if (w_fill_done)  w_full_nxt[r_wr_sel] = 1'b1;
    if (w_drain_done) w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= R_IDLE;
      r_wr_sel    <= BANK0;
      r_rd_sel    <= BANK0;
      r_bank_full <= 2'b00;
      r_slice     <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bank_full <= w_full_nxt;
      r_rd_valid  <= w_reading;
      r_rd_bank   <= r_rd_sel;
      r_rd_last   <= w_drain_done;
      if (w_fill_done) begin
        r_wr_sel <= (r_wr_sel == BANK0) ? BANK1 : BANK0;
      end
      if (w_drain_done) begin
        r_rd_sel <= (r_rd_sel == BANK0) ? BANK1 : BANK0;
        r_slice  <= '0;
      end else if (w_slice_end) begin
        r_slice  <= r_slice + 1'b1;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.bank0_ena   = w_beat & (r_wr_sel == BANK0);
  assign bus.bank0_wea   = w_beat & (r_wr_sel == BANK0);
  assign bus.bank1_ena   = w_beat & (r_wr_sel == BANK1);
  assign bus.bank1_wea   = w_beat & (r_wr_sel == BANK1);
  assign bus.bank0_addra = (r_wr_sel == BANK0) ? w_wr_cnt : '0;
  assign bus.bank1_addra = (r_wr_sel == BANK1) ? w_wr_cnt : '0;
  assign bus.bank0_enb   = w_reading & (r_rd_sel == BANK0);
  assign bus.bank1_enb   = w_reading & (r_rd_sel == BANK1);
  assign bus.bank0_web   = 1'b0;
  assign bus.bank1_web   = 1'b0;
  assign bus.bank0_addrb = (w_reading && r_rd_sel == BANK0) ? w_rd_cnt : '0;
  assign bus.bank1_addrb = (w_reading && r_rd_sel == BANK1) ? w_rd_cnt : '0;
  assign bus.slicing_idx = r_slice;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_bank     = r_rd_bank;
  assign bus.rd_last     = r_rd_last;
  assign bus.bank_full   = r_bank_full;

endmodule
`default_nettype wire

// File: doc/ping_pong_w_ctrl.md
PING_PONG_W_CTRL -- requirements
Module: ping_pong_w_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the bank address width.
REQ-002 SHALL have parameter TOTAL_DEPTH, default 12, the words written per bank fill (at least 2).
REQ-003 SHALL have parameter TOTAL_MODULES, default 4, the slice passes read per bank (at least 1).
REQ-004 SHALL have ports `clk` (in, 1, the single clock) and `rst_n` (in, 1, reset: asynchronous, active-low).
REQ-005 SHALL have ports `in_valid` (in, 1) and `in_ready` (out, 1), the write handshake from the linear projection.
REQ-006 SHALL have port `sa_ready` (in, 1): the systolic array can accept a full bank drain.
REQ-007 SHALL have ports `bank0_ena`, `bank0_wea`, `bank1_ena`, `bank1_wea` (out, 1 each): write port A controls.
REQ-008 SHALL have ports `bank0_addra` and `bank1_addra` (out, ADDR_WIDTH each): write addresses.
REQ-009 SHALL have ports `bank0_enb` and `bank1_enb` (out, 1 each): read port B enables.
REQ-010 SHALL have ports `bank0_web` and `bank1_web` (out, 1 each), tied to 0.
REQ-011 SHALL have ports `bank0_addrb` and `bank1_addrb` (out, ADDR_WIDTH each): read addresses.
REQ-012 SHALL have port `slicing_idx` (out, $clog2(TOTAL_MODULES)): the current slice pass.
REQ-013 SHALL have ports `rd_valid`, `rd_bank`, `rd_last` (out, 1 each): read data valid, selected bank, final word of the drain.
REQ-014 SHALL have port `bank_full` (out, 2): per-bank full flags.

Function
REQ-015 SHALL accept a beat when `in_valid` and `in_ready` are both high; the beat asserts ena/wea of bank `wr_sel` at `addra` = wr_cnt, and wr_cnt increments.
REQ-016 SHALL, on the beat with wr_cnt = TOTAL_DEPTH-1, set `bank_full[wr_sel]`, clear wr_cnt and toggle `wr_sel`.
REQ-017 SHALL hold `in_ready` = !bank_full[wr_sel], so writes stall while both banks are full.
REQ-018 SHALL implement the read FSM R_IDLE -> R_READ -> R_IDLE.
REQ-019 SHALL move R_IDLE -> R_READ when bank_full[rd_sel] and `sa_ready` are both high.
REQ-020 SHALL, in R_READ, assert enb of bank `rd_sel` every cycle with `addrb` = rd_cnt; rd_cnt runs 0..TOTAL_DEPTH-1, then `slicing_idx` increments.
REQ-021 SHALL run a drain uninterrupted once started, taking exactly TOTAL_MODULES*TOTAL_DEPTH cycles and ignoring `sa_ready`.
REQ-022 SHALL, after the last read (slice TOTAL_MODULES-1, addr TOTAL_DEPTH-1), clear bank_full[rd_sel], toggle rd_sel, zero `slicing_idx` and return to R_IDLE on the next edge.
REQ-023 SHALL assert `rd_valid` one cycle after each enb (1-cycle BRAM latency), with `rd_bank` the bank read and `rd_last` high only for the final word.
REQ-024 SHALL apply both updates when a fill completes and a drain frees the other bank in the same cycle: bank_full becomes the set of the filled bank and the clear of the drained one.
REQ-025 SHALL allow the write and read sides to use different banks concurrently, and SHALL never select the same bank for both.
REQ-026 SHALL allow back-to-back drains: if the next bank is full and `sa_ready` is high at the return to R_IDLE, R_READ re-enters after exactly 1 R_IDLE cycle.

Reset
REQ-027 SHALL, while `rst_n` is low, asynchronously drive all enables, `rd_valid`, `rd_last`, `rd_bank`, `bank_full`, `slicing_idx` and the addresses to 0, wr_sel/rd_sel to bank 0 and the FSM to R_IDLE.
REQ-028 SHALL abandon any partial fill or drain on reset mid-operation; `in_ready` = 1 on the first edge after release.

Structure
REQ-029 SHALL take the read-FSM state enum and the bank-select type from the shared package ping_pong_pkg.
REQ-030 SHALL use the single sub-module pp_addr_counter (wrap counter with terminal flag), instantiated once for the write side and once for the read address.

Verification
REQ-031 SHALL cover: 12 consecutive beats -> bank0 addra 0..11, then bank_full = 01, wr_sel = 1, in_ready = 1.
REQ-032 SHALL cover: 24 beats with sa_ready = 0 -> bank_full = 11, in_ready = 0, the 25th beat is held.
REQ-033 SHALL cover: bank0 full, sa_ready = 1 -> 48 enb cycles, addrb 0..11 repeated for slicing_idx 0..3, rd_valid lagging enb by 1 cycle, rd_last on the 48th valid, bank_full[0] then cleared.
REQ-034 SHALL cover: a bank1 fill completing on the same cycle as the bank0 drain end -> bank_full = 10, and the read of bank1 starts 1 cycle later.
REQ-035 SHALL cover: rst_n low at drain cycle 20 -> outputs 0 immediately, and a fresh fill after release starts at bank0 address 0.
